ifetch_prefetch: RTL and testbench

Instruction prefetch stage sitting directly upstream of `sync_fifo` in rvcpu. It walks a program counter, issues one single-word read at a time to instruction memory, and pushes each returned 32-bit word into the FIFO through its `write`/`wData` port, never while `full`. A redirect (branch/trap) reloads the PC, flushes the FIFO and discards any in-flight response. A memory error parks the unit until the next redirect.

---
 rtl/rvcpu_pkg.sv | 21 ++
 rtl/ifetch_prefetch.sv | 120 ++++++++++++
 tb/tb_ifetch_prefetch.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvcpu_pkg.sv
// Shared rvcpu definitions: datapath width, fetch FSM encoding and the
// default program-counter step used by the prefetch stage.
package rvcpu_pkg;

   localparam int XLEN = 32;

   // Byte increment between consecutive instruction words.
   localparam logic [XLEN-1:0] PC_STEP_DEFAULT = 32'd4;

   // IDLE : free to issue a request
   // WAIT : one request outstanding, its response will be pushed
   // DROP : one stale request outstanding, its response is thrown away
   // HALT : parked after a bus error until the next redirect
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2,
      HALT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage. Walks a PC, keeps at most one single-word
// read in flight, and pushes each good response into the downstream FIFO.
// A redirect reloads the PC, flushes the FIFO and orphans any in-flight read;
// a bus error parks the unit until the next redirect.
module ifetch_prefetch
   import rvcpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirectPc,
   output logic            memReq,
   output logic [XLEN-1:0] memAddr,
   input  logic            memAck,
   input  logic [XLEN-1:0] memData,
   input  logic            memErr,
   output logic            write,
   output logic [XLEN-1:0] wData,
   input  logic            full,
   output logic            fifoFlush,
   output logic            errFlag,
   output logic [XLEN-1:0] fetchPc
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_memAddr;
   logic [XLEN-1:0] r_wData;
   logic            r_write;
   logic            r_fifoFlush;
   logic            r_errFlag;

   logic            w_issue;
   logic            w_ackOk;
   logic            w_ackErr;

   // The !r_write term covers the cycle where our own push has not yet
   // reached the FIFO's full flag. A redirect suppresses issue so the old
   // PC is never requested on the cycle it is being replaced.
   assign w_issue  = (r_state == IDLE) && run && !full && !r_write && !redirect;

   // Only a response to a live request is consumed; a same-cycle redirect
   // overrides both a good response and an error.
   assign w_ackOk  = (r_state == WAIT) && memAck && !memErr && !redirect;
   assign w_ackErr = (r_state == WAIT) && memAck &&  memErr && !redirect;

   // Next-state logic: redirect first, then the normal walk.
   always_comb begin
      w_state_next = r_state;
      if (redirect) begin
         // A request still in flight after this cycle must be drained in DROP.
         if (((r_state == WAIT) || (r_state == DROP)) && !memAck)
            w_state_next = DROP;
         else
            w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_issue) w_state_next = WAIT;
            WAIT:    if (memAck)  w_state_next = memErr ? HALT : IDLE;
            DROP:    if (memAck)  w_state_next = IDLE;
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   // PC register: reload on redirect, advance on each accepted word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_pc <= RESET_PC;
      else if (redirect) r_pc <= redirectPc;
      else if (w_ackOk)  r_pc <= r_pc + PC_STEP;
   end

   // Latch the issued address so memAddr stays put after the request pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_memAddr <= '0;
      else if (w_issue) r_memAddr <= r_pc;
   end

   // FIFO push, flush and sticky error outputs, all registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_write     <= 1'b0;
         r_wData     <= '0;
         r_fifoFlush <= 1'b0;
         r_errFlag   <= 1'b0;
      end else begin
         r_write     <= w_ackOk;
         r_fifoFlush <= redirect;
         if (w_ackOk)
            r_wData <= memData;
         if (redirect)
            r_errFlag <= 1'b0;
         else if (w_ackErr)
            r_errFlag <= 1'b1;
      end
   end

   // During the pulse the address comes straight from the PC register;
   // afterwards the latched copy holds it until the next issue.
   assign memReq    = w_issue;
   assign memAddr   = w_issue ? r_pc : r_memAddr;
   assign write     = r_write;
   assign wData     = r_wData;
   assign fifoFlush = r_fifoFlush;
   assign errFlag   = r_errFlag;
   assign fetchPc   = r_pc;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: a memory responder and FIFO
// occupancy model drive the DUT; directed tasks cover the documented
// scenarios and a randomized task compares the push stream to the expected
// sequential instruction stream since the last redirect.
module tb_ifetch_prefetch;
   import rvcpu_pkg::*;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        run        = 1'b0;
   logic        redirect   = 1'b0;
   logic [31:0] redirectPc = 32'h0;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck     = 1'b0;
   logic [31:0] memData    = 32'h0;
   logic        memErr     = 1'b0;
   logic        write;
   logic [31:0] wData;
   logic        full       = 1'b0;
   logic        fifoFlush;
   logic        errFlag;
   logic [31:0] fetchPc;

   int tests = 0;
   int fails = 0;

   // Environment knobs
   int          cyc      = 0;
   bit          resp_en  = 1'b1;
   bit          lat_rand = 1'b0;
   int          lat_fix  = 1;
   bit          err_en   = 1'b0;
   logic [31:0] err_addr = 32'h0;
   int          depth    = 1000;
   bit          drain_en = 1'b1;
   bit          man_ack  = 1'b0;

   // Environment state
   bit          pend       = 1'b0;
   int          cnt        = 0;
   logic [31:0] paddr      = 32'h0;
   bit          seen_req   = 1'b0;
   logic [31:0] seen_addr  = 32'h0;
   bit          seen_flush = 1'b0;
   int          fifo_cnt   = 0;
   bit          outst      = 1'b0;
   int          flush_cnt  = 0;

   logic [31:0] req_addr_q[$];
   int          req_cyc_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];

   always #5 clk = ~clk;

   ifetch_prefetch dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .memReq     (memReq),
      .memAddr    (memAddr),
      .memAck     (memAck),
      .memData    (memData),
      .memErr     (memErr),
      .write      (write),
      .wData      (wData),
      .full       (full),
      .fifoFlush  (fifoFlush),
      .errFlag    (errFlag),
      .fetchPc    (fetchPc)
   );

   // Instruction memory contents: 0x13, 0x93, 0x113, ... at 0x0, 0x4, 0x8, ...
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return 32'h0000_0013 + (a << 5);
   endfunction

   // Memory responder and FIFO occupancy, driven just after the rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      memAck  = 1'b0;
      memErr  = 1'b0;
      memData = 32'h0;
      if (!rst) begin
         pend = 1'b0; man_ack = 1'b0; fifo_cnt = 0; seen_req = 1'b0; seen_flush = 1'b0;
      end else begin
         if (seen_req) begin
            pend = 1'b1; paddr = seen_addr; seen_req = 1'b0;
            cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
         end
         if (pend) begin
            if (man_ack || (resp_en && cnt <= 1)) begin
               memAck  = 1'b1;
               memData = memfn(paddr);
               memErr  = err_en && (paddr == err_addr);
               pend    = 1'b0;
               man_ack = 1'b0;
            end else if (resp_en) begin
               cnt--;
            end
         end
         if (seen_flush) begin
            fifo_cnt = 0; seen_flush = 1'b0;
         end else if (drain_en && fifo_cnt > 0 && $urandom_range(0, 1) == 1) begin
            fifo_cnt--;
         end
      end
      full = (fifo_cnt >= depth);
   end

   // Protocol monitor: logs transactions and checks the block's invariants.
   always @(negedge clk) begin
      if (!rst) begin
         outst = 1'b0;
      end else begin
         if (memReq) begin
            if (dut.r_state !== IDLE) begin
               fails++; $display("FAIL req_state: memReq with state %0d, required %0d", dut.r_state, IDLE);
            end
            if (outst) begin
               fails++; $display("FAIL one_outstanding: memReq at %h while a request is in flight, required none", memAddr);
            end
            outst = 1'b1; seen_req = 1'b1; seen_addr = memAddr;
            req_addr_q.push_back(memAddr); req_cyc_q.push_back(cyc);
            $display("[TB] cyc %0d req addr=%h", cyc, memAddr);
         end
         if (memAck) outst = 1'b0;
         if (write) begin
            if (full) begin
               fails++; $display("FAIL write_full: write=1 with full=1, required write=0");
            end
            if (fifoFlush) begin
               fails++; $display("FAIL write_flush: write=1 with fifoFlush=1, required not both");
            end
            fifo_cnt++;
            wr_data_q.push_back(wData); wr_cyc_q.push_back(cyc);
            $display("[TB] cyc %0d push data=%h", cyc, wData);
         end
         if (fifoFlush) begin
            flush_cnt++; seen_flush = 1'b1;
            $display("[TB] cyc %0d flush", cyc);
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      @(posedge clk); #3;
      rst = 1'b0; run = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
      resp_en = 1'b1; lat_rand = 1'b0; lat_fix = 1; err_en = 1'b0; err_addr = 32'h0;
      depth = 1000; drain_en = 1'b1; man_ack = 1'b0; flush_cnt = 0;
      repeat (2) @(posedge clk);
      req_addr_q.delete(); req_cyc_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      #2 rst = 1'b1;
   endtask

   task automatic wait_reqs(input int n, input int budget);
      for (int i = 0; i < budget && req_addr_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_writes(input int n, input int budget);
      for (int i = 0; i < budget && wr_data_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (memReq !== 1'b0) begin fails++; $display("FAIL rst_memReq: got %b required 0", memReq); end
      tests++; if (memAddr !== 32'h0) begin fails++; $display("FAIL rst_memAddr: got %h required 0", memAddr); end
      tests++; if (write !== 1'b0) begin fails++; $display("FAIL rst_write: got %b required 0", write); end
      tests++; if (wData !== 32'h0) begin fails++; $display("FAIL rst_wData: got %h required 0", wData); end
      tests++; if (fifoFlush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b required 0", fifoFlush); end
      tests++; if (errFlag !== 1'b0) begin fails++; $display("FAIL rst_errFlag: got %b required 0", errFlag); end
      tests++; if (fetchPc !== 32'h0) begin fails++; $display("FAIL rst_fetchPc: got %h required 0", fetchPc); end
      tests++; if (dut.r_state !== IDLE) begin fails++; $display("FAIL rst_state: got %0d required IDLE", dut.r_state); end
   endtask

   task automatic test_stream;
      do_reset();
      tick(); run = 1'b1;
      repeat (14) tick();
      @(negedge clk);
      tests++;
      if (req_addr_q.size() < 4 || wr_data_q.size() < 4) begin
         fails++; $display("FAIL stream_count: got %0d reqs %0d pushes, required at least 4 each", req_addr_q.size(), wr_data_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++; if (req_addr_q[i] !== 32'(4 * i)) begin fails++; $display("FAIL stream_addr%0d: got %h required %h", i, req_addr_q[i], 32'(4 * i)); end
            tests++; if (wr_data_q[i] !== memfn(32'(4 * i))) begin fails++; $display("FAIL stream_data%0d: got %h required %h", i, wr_data_q[i], memfn(32'(4 * i))); end
            tests++; if (wr_cyc_q[i] != req_cyc_q[i] + 2) begin fails++; $display("FAIL stream_lat%0d: push at %0d required %0d", i, wr_cyc_q[i], req_cyc_q[i] + 2); end
            if (i > 0) begin
               tests++; if (req_cyc_q[i] - req_cyc_q[i-1] != 3) begin fails++; $display("FAIL stream_cadence%0d: got %0d cycles required 3", i, req_cyc_q[i] - req_cyc_q[i-1]); end
            end
         end
      end
   endtask

   task automatic test_full;
      do_reset();
      depth = 2; drain_en = 1'b0;
      tick(); run = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      tests++; if (req_addr_q.size() != 2) begin fails++; $display("FAIL full_reqs: got %0d requests required 2", req_addr_q.size()); end
      tests++; if (wr_data_q.size() != 2) begin fails++; $display("FAIL full_pushes: got %0d pushes required 2", wr_data_q.size()); end
      tests++; if (memReq !== 1'b0) begin fails++; $display("FAIL full_memReq: got %b required 0", memReq); end
      tests++; if (fetchPc !== 32'h8) begin fails++; $display("FAIL full_fetchPc: got %h required 8", fetchPc); end
      drain_en = 1'b1;
      wait_reqs(3, 40);
      tests++;
      if (req_addr_q.size() < 3) begin
         fails++; $display("FAIL full_resume: got %0d requests required 3 after drain", req_addr_q.size());
      end else if (req_addr_q[2] !== 32'h8) begin
         fails++; $display("FAIL full_resume: got addr %h required 8", req_addr_q[2]);
      end
   endtask

   task automatic test_redirect_wait;
      do_reset();
      resp_en = 1'b0;
      tick(); run = 1'b1;
      wait_reqs(1, 10);
      tick(); redirect = 1'b1; redirectPc = 32'h100;
      tick(); redirect = 1'b0;
      @(negedge clk);
      tests++; if (fifoFlush !== 1'b1) begin fails++; $display("FAIL rw_flush: got %b required 1", fifoFlush); end
      tests++; if (dut.r_state !== DROP) begin fails++; $display("FAIL rw_state: got %0d required DROP", dut.r_state); end
      tests++; if (fetchPc !== 32'h100) begin fails++; $display("FAIL rw_fetchPc: got %h required 100", fetchPc); end
      man_ack = 1'b1; resp_en = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      tests++; if (flush_cnt != 1) begin fails++; $display("FAIL rw_flush_count: got %0d required 1", flush_cnt); end
      tests++;
      if (req_addr_q.size() < 2 || wr_data_q.size() < 1) begin
         fails++; $display("FAIL rw_resume: got %0d reqs %0d pushes, required 2 and 1", req_addr_q.size(), wr_data_q.size());
      end else begin
         if (req_addr_q[1] !== 32'h100) begin fails++; $display("FAIL rw_resume: got addr %h required 100", req_addr_q[1]); end
         tests++; if (wr_data_q[0] !== memfn(32'h100)) begin fails++; $display("FAIL rw_first_push: got %h required %h", wr_data_q[0], memfn(32'h100)); end
      end
   endtask

   task automatic test_redirect_ack;
      do_reset();
      resp_en = 1'b0; err_en = 1'b1; err_addr = 32'h0;
      tick(); run = 1'b1;
      wait_reqs(1, 10);
      man_ack = 1'b1;
      tick(); redirect = 1'b1; redirectPc = 32'h200;
      tick(); redirect = 1'b0;
      @(negedge clk);
      tests++; if (write !== 1'b0) begin fails++; $display("FAIL ra_write: got %b required 0", write); end
      tests++; if (fetchPc !== 32'h200) begin fails++; $display("FAIL ra_fetchPc: got %h required 200", fetchPc); end
      tests++; if (dut.r_state !== IDLE) begin fails++; $display("FAIL ra_state: got %0d required IDLE", dut.r_state); end
      tests++; if (errFlag !== 1'b0) begin fails++; $display("FAIL ra_errFlag: got %b required 0", errFlag); end
      tests++; if (fifoFlush !== 1'b1) begin fails++; $display("FAIL ra_flush: got %b required 1", fifoFlush); end
      err_en = 1'b0; resp_en = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      tests++;
      if (wr_data_q.size() < 1) begin
         fails++; $display("FAIL ra_resume: got 0 pushes required at least 1");
      end else if (wr_data_q[0] !== memfn(32'h200)) begin
         fails++; $display("FAIL ra_resume: got %h required %h", wr_data_q[0], memfn(32'h200));
      end
   endtask

   task automatic test_error;
      do_reset();
      err_en = 1'b1; err_addr = 32'h8;
      tick(); run = 1'b1;
      repeat (25) tick();
      @(negedge clk);
      tests++; if (req_addr_q.size() != 3) begin fails++; $display("FAIL err_reqs: got %0d requests required 3", req_addr_q.size()); end
      tests++; if (wr_data_q.size() != 2) begin fails++; $display("FAIL err_pushes: got %0d pushes required 2", wr_data_q.size()); end
      tests++; if (errFlag !== 1'b1) begin fails++; $display("FAIL err_flag: got %b required 1", errFlag); end
      tests++; if (fetchPc !== 32'h8) begin fails++; $display("FAIL err_fetchPc: got %h required 8", fetchPc); end
      tests++; if (dut.r_state !== HALT) begin fails++; $display("FAIL err_state: got %0d required HALT", dut.r_state); end
      err_en = 1'b0;
      tick(); redirect = 1'b1; redirectPc = 32'h40;
      tick(); redirect = 1'b0;
      @(negedge clk);
      tests++; if (errFlag !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", errFlag); end
      repeat (10) tick();
      @(negedge clk);
      tests++;
      if (req_addr_q.size() < 4 || wr_data_q.size() < 3) begin
         fails++; $display("FAIL err_resume: got %0d reqs %0d pushes, required 4 and 3", req_addr_q.size(), wr_data_q.size());
      end else begin
         if (req_addr_q[3] !== 32'h40) begin fails++; $display("FAIL err_resume: got addr %h required 40", req_addr_q[3]); end
         tests++; if (wr_data_q[2] !== memfn(32'h40)) begin fails++; $display("FAIL err_resume_data: got %h required %h", wr_data_q[2], memfn(32'h40)); end
      end
   endtask

   task automatic test_wrap;
      do_reset();
      tick(); redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
      tick(); redirect = 1'b0; run = 1'b1;
      wait_writes(1, 20);
      tests++;
      if (wr_data_q.size() < 1) begin
         fails++; $display("FAIL wrap_push: got 0 pushes required 1");
      end else begin
         if (wr_data_q[0] !== memfn(32'hFFFF_FFFC)) begin fails++; $display("FAIL wrap_push: got %h required %h", wr_data_q[0], memfn(32'hFFFF_FFFC)); end
         tests++; if (fetchPc !== 32'h0) begin fails++; $display("FAIL wrap_fetchPc: got %h required 0", fetchPc); end
      end
      wait_reqs(2, 20);
      tests++;
      if (req_addr_q.size() < 2) begin
         fails++; $display("FAIL wrap_next: got %0d requests required 2", req_addr_q.size());
      end else if (req_addr_q[1] !== 32'h0) begin
         fails++; $display("FAIL wrap_next: got addr %h required 0", req_addr_q[1]);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      tick(); run = 1'b1;
      wait_writes(1, 20);
      resp_en = 1'b0;
      wait_reqs(2, 20);
      @(posedge clk); #3;
      rst = 1'b0; run = 1'b0;
      #1;
      tests++; if (dut.r_state !== IDLE) begin fails++; $display("FAIL areset_state: got %0d required IDLE", dut.r_state); end
      tests++; if (fetchPc !== 32'h0) begin fails++; $display("FAIL areset_fetchPc: got %h required 0", fetchPc); end
      repeat (2) @(posedge clk);
      req_addr_q.delete(); req_cyc_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      resp_en = 1'b1;
      #2 rst = 1'b1;
      tick(); run = 1'b1;
      wait_writes(1, 20);
      tests++;
      if (wr_data_q.size() < 1) begin
         fails++; $display("FAIL areset_restart: got 0 pushes required 1");
      end else if (wr_data_q[0] !== memfn(32'h0)) begin
         fails++; $display("FAIL areset_restart: got %h required %h", wr_data_q[0], memfn(32'h0));
      end
   endtask

   task automatic test_random;
      logic [31:0] base;
      logic [31:0] nbase;
      logic [31:0] v;
      logic [31:0] exp_data;
      int          idx;
      int          checked;
      bit          rebase;
      do_reset();
      lat_rand = 1'b1;
      depth    = int'($urandom_range(2, 5));
      base = 32'h0; nbase = 32'h0; idx = 0; checked = 0; rebase = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         // A push seen in the redirect cycle still belongs to the old stream.
         if (write) begin
            exp_data = memfn(base + 32'(idx) * 32'd4);
            tests++;
            if (wData !== exp_data) begin
               fails++; $display("FAIL rand_push%0d: got %h required %h", checked, wData, exp_data);
            end
            idx++; checked++;
         end
         if (rebase) begin base = nbase; idx = 0; rebase = 1'b0; end
         tick();
         run = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) begin
            v = $urandom; v[1:0] = 2'b00;
            redirect = 1'b1; redirectPc = v; nbase = v; rebase = 1'b1;
         end else begin
            redirect = 1'b0;
         end
      end
      redirect = 1'b0; run = 1'b0;
      tests++;
      if (checked < 20) begin fails++; $display("FAIL rand_progress: got %0d pushes required at least 20", checked); end
   endtask

   initial begin
      #2 rst = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_error();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
